// File: rtl/dct_pkg.sv
// dct_pkg: definitions shared by the forward and inverse binDCT math.
//   frac_e      : shift-set selector for the lifting fractions
//   calc_w_int  : internal Q.3 width from the input sample width
//   OUT_PERM    : output permutation, y[k] = e[OUT_PERM[k]]
//   round_q3    : R(), rounds a Q.3 value to the integer grid, ties away from zero
package dct_pkg;

  typedef enum logic [2:0] {
    FRAC_3_8 = 3'd0,
    FRAC_5_8 = 3'd1,
    FRAC_7_8 = 3'd2,
    FRAC_1_2 = 3'd3,
    FRAC_1_8 = 3'd4
  } frac_e;

  // Three fractional bits plus three bits of butterfly/lifting growth.
  function automatic int calc_w_int(input int w_i);
    return w_i + 32'sd6;
  endfunction

  // Packed as {src(y7), ..., src(y0)}.
  localparam logic [7:0][2:0] OUT_PERM = {3'd4, 3'd2, 3'd5, 3'd1, 3'd6, 3'd3, 3'd7, 3'd0};

  // Adding 4 (positive) or 3 (negative) and then flooring to a multiple of 8
  // rounds to nearest with ties away from zero: -3.5 -> -4, 3.5 -> 4.
  function automatic logic signed [63:0] round_q3(input logic signed [63:0] v);
    logic signed [63:0] t;
    t = v + (v[63] ? 64'sd3 : 64'sd4);
    return t & 64'hFFFF_FFFF_FFFF_FFF8;
  endfunction

endpackage

// File: rtl/dct_ft_math_if.sv
// dct_ft_math_if: valid-qualified vector of 8 signed lanes (no backpressure).
//   valid : qualifies data
//   data  : 8 lanes of W bits, lane 0 in bits [W-1:0]
// master drives the bus, slave receives it.
interface dct_ft_math_if #(
  parameter int W = 16
);
  logic              valid;
  logic [7:0][W-1:0] data;

  modport master (output valid, output data);
  modport slave  (input  valid, input  data);
endinterface

// File: rtl/dct_lift.sv
// dct_lift: combinational lifting multiply, o_r = R(fraction * i_v).
//   i_sel : which fraction (3/8, 5/8, 7/8, 1/2, 1/8)
//   i_v   : Q.3 operand
//   o_r   : rounded Q.3 result on the integer grid
// The fraction is formed as a sum of arithmetic shifts of the Q.3 operand;
// rounding is applied once, to the sum.
module dct_lift
  import dct_pkg::*;
#(
  parameter int W = 22
) (
  input  frac_e                i_sel,
  input  logic signed [W-1:0]  i_v,
  output logic signed [W-1:0]  o_r
);

  logic signed [W-1:0] w_sum;

  // Shift-sum for the selected fraction, then round to the integer grid.
  always_comb begin
    w_sum = '0;
    case (i_sel)
      FRAC_3_8: w_sum = (i_v >>> 3'd3) + (i_v >>> 3'd2);
      FRAC_5_8: w_sum = (i_v >>> 3'd3) + (i_v >>> 3'd1);
      FRAC_7_8: w_sum = (i_v >>> 3'd3) + (i_v >>> 3'd2) + (i_v >>> 3'd1);
      FRAC_1_2: w_sum = (i_v >>> 3'd1);
      FRAC_1_8: w_sum = (i_v >>> 3'd3);
      default:  w_sum = '0;
    endcase
    o_r = W'(round_q3(64'(w_sum)));
  end

endmodule

// File: rtl/dct_ft_math.sv
// dct_ft_math: pipelined 1-D forward binDCT of 8 signed samples.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   i_in  : samples x0..x7 (W_I bits) with valid
//   o_out : coefficients y0..y7 (W_O bits) with valid, 8 cycles later
// Each stage register loads only when the valid entering it is set, so the
// output holds the last result between vectors.
module dct_ft_math
  import dct_pkg::*;
#(
  parameter int W_I = 16,
  parameter int W_O = W_I + 3
) (
  input logic              clk,
  input logic              rst,
  dct_ft_math_if.slave     i_in,
  dct_ft_math_if.master    o_out
);

  localparam int W_INT = calc_w_int(W_I);
  typedef logic signed [W_INT-1:0] q_t;
  typedef logic signed [W_O-1:0]   y_t;

  q_t r_s0 [8];
  q_t r_s1 [8];
  q_t r_s2 [8];
  q_t r_s3 [8];
  q_t r_s4 [8];
  q_t r_s5 [8];
  q_t r_s6 [8];
  y_t r_s7 [8];
  logic [7:0][W_O-1:0] r_out;
  logic [8:0]          r_vld;

  q_t w_s0 [8];
  q_t w_s1 [8];
  q_t w_s2 [8];
  q_t w_s3 [8];
  q_t w_s4 [8];
  q_t w_s5 [8];
  q_t w_s6 [8];
  y_t w_s7 [8];

  q_t w_l2, w_l3, w_l5_c3, w_l5_c7, w_l5_c6, w_l6_e0, w_l6_e2, w_l6_e5;

  dct_lift #(.W(W_INT)) u_l2    (.i_sel(FRAC_3_8), .i_v(r_s1[5]), .o_r(w_l2));
  dct_lift #(.W(W_INT)) u_l3    (.i_sel(FRAC_5_8), .i_v(r_s2[6]), .o_r(w_l3));
  dct_lift #(.W(W_INT)) u_l5_c3 (.i_sel(FRAC_3_8), .i_v(r_s4[3]), .o_r(w_l5_c3));
  dct_lift #(.W(W_INT)) u_l5_c7 (.i_sel(FRAC_1_8), .i_v(r_s4[7]), .o_r(w_l5_c7));
  dct_lift #(.W(W_INT)) u_l5_c6 (.i_sel(FRAC_7_8), .i_v(r_s4[6]), .o_r(w_l5_c6));
  dct_lift #(.W(W_INT)) u_l6_e0 (.i_sel(FRAC_1_2), .i_v(r_s5[0]), .o_r(w_l6_e0));
  dct_lift #(.W(W_INT)) u_l6_e2 (.i_sel(FRAC_3_8), .i_v(r_s5[2]), .o_r(w_l6_e2));
  dct_lift #(.W(W_INT)) u_l6_e5 (.i_sel(FRAC_1_2), .i_v(r_s5[5]), .o_r(w_l6_e5));

  // S0/S1: sign-extend into Q.3, then the first butterfly.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_s0[i] = q_t'($signed(i_in.data[i])) <<< 3'd3;
    end
    w_s1 = r_s0;
    for (int i = 0; i < 4; i++) begin
      w_s1[i]     = r_s0[i] + r_s0[7-i];
      w_s1[7-i]   = r_s0[i] - r_s0[7-i];
    end
  end

  // S2/S3: odd-half lifting pair; S3 uses the b6 already updated by S2.
  always_comb begin
    w_s2    = r_s1;
    w_s2[6] = r_s1[6] + w_l2;
    w_s3    = r_s2;
    w_s3[5] = w_l3 - r_s2[5];
  end

  // S4: second butterfly; note c6 = b7 - b6 (reversed order).
  always_comb begin
    w_s4    = r_s3;
    w_s4[0] = r_s3[0] + r_s3[3];
    w_s4[3] = r_s3[0] - r_s3[3];
    w_s4[1] = r_s3[1] + r_s3[2];
    w_s4[2] = r_s3[1] - r_s3[2];
    w_s4[4] = r_s3[4] + r_s3[5];
    w_s4[5] = r_s3[4] - r_s3[5];
    w_s4[7] = r_s3[6] + r_s3[7];
    w_s4[6] = r_s3[7] - r_s3[6];
  end

  // S5/S6: final lifting; lanes not listed pass through unchanged.
  always_comb begin
    w_s5    = r_s4;
    w_s5[0] = r_s4[0] + r_s4[1];
    w_s5[2] = r_s4[2] - w_l5_c3;
    w_s5[4] = r_s4[4] - w_l5_c7;
    w_s5[5] = r_s4[5] + w_l5_c6;
    w_s6    = r_s5;
    w_s6[1] = w_l6_e0 - r_s5[1];
    w_s6[3] = r_s5[3] + w_l6_e2;
    w_s6[6] = r_s5[6] - w_l6_e5;
  end

  // S7: drop the fraction bits and reorder into frequency order.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      w_s7[k] = y_t'(r_s6[OUT_PERM[k]] >>> 3'd3);
    end
  end

  // Stage registers and valid pipeline; each stage loads only on its valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_out <= '0;
      for (int i = 0; i < 8; i++) begin
        r_s0[i] <= '0;
        r_s1[i] <= '0;
        r_s2[i] <= '0;
        r_s3[i] <= '0;
        r_s4[i] <= '0;
        r_s5[i] <= '0;
        r_s6[i] <= '0;
        r_s7[i] <= '0;
      end
    end else begin
      r_vld <= {r_vld[7:0], i_in.valid};
      if (i_in.valid) r_s0 <= w_s0;
      if (r_vld[0])   r_s1 <= w_s1;
      if (r_vld[1])   r_s2 <= w_s2;
      if (r_vld[2])   r_s3 <= w_s3;
      if (r_vld[3])   r_s4 <= w_s4;
      if (r_vld[4])   r_s5 <= w_s5;
      if (r_vld[5])   r_s6 <= w_s6;
      if (r_vld[6])   r_s7 <= w_s7;
      if (r_vld[7]) begin
        for (int k = 0; k < 8; k++) begin
          r_out[k] <= r_s7[k];
        end
      end
    end
  end

  assign o_out.valid = r_vld[8];
  assign o_out.data  = r_out;

endmodule

// File: tb/tb_dct_ft_math.sv
module tb_dct_ft_math;

  localparam int W_I = 16;
  localparam int W_O = W_I + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dct_ft_math_if #(.W(W_I)) u_in ();
  dct_ft_math_if #(.W(W_O)) u_out ();

  dct_ft_math #(.W_I(W_I), .W_O(W_O)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .i_in  (u_in),
    .o_out (u_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model (plain integer arithmetic) ----------------
  function automatic int fdiv(input int v, input int d);
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  // Round a value in eighths to a whole multiple of 8, ties away from zero.
  function automatic int rnd(input int v);
    if (v >= 0) return ((v + 4) / 8) * 8;
    return -(((-v + 4) / 8) * 8);
  endfunction

  // R(num8/8 * v): bit j of num8 contributes floor(v / 2^(3-j)).
  function automatic int lift(input int v, input int num8);
    int s;
    s = 0;
    if (num8 % 2 == 1)       s += fdiv(v, 8);
    if ((num8 / 2) % 2 == 1) s += fdiv(v, 4);
    if ((num8 / 4) % 2 == 1) s += fdiv(v, 2);
    return rnd(s);
  endfunction

  function automatic void ref_dct(input int x[8], output int y[8]);
    int a[8];
    int b[8];
    int c[8];
    int e[8];
    int perm[8];
    perm = '{0, 7, 3, 6, 1, 5, 2, 4};
    for (int i = 0; i < 8; i++) a[i] = x[i] * 8;
    for (int i = 0; i < 4; i++) begin
      b[i]   = a[i] + a[7-i];
      b[7-i] = a[i] - a[7-i];
    end
    b[6] = b[6] + lift(b[5], 3);
    b[5] = lift(b[6], 5) - b[5];
    c[0] = b[0] + b[3]; c[3] = b[0] - b[3];
    c[1] = b[1] + b[2]; c[2] = b[1] - b[2];
    c[4] = b[4] + b[5]; c[5] = b[4] - b[5];
    c[7] = b[6] + b[7]; c[6] = b[7] - b[6];
    e[0] = c[0] + c[1];
    e[2] = c[2] - lift(c[3], 3);
    e[4] = c[4] - lift(c[7], 1);
    e[5] = c[5] + lift(c[6], 7);
    e[1] = lift(e[0], 4) - c[1];
    e[3] = c[3] + lift(e[2], 3);
    e[6] = c[6] - lift(e[5], 4);
    e[7] = c[7];
    for (int k = 0; k < 8; k++) y[k] = fdiv(e[perm[k]], 8);
  endfunction

  // ---------------- check helpers ----------------
  task automatic chk_bit(input string nm, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: out_valid got %0b, expected %0b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_vec(input string nm, input int exp[8]);
    int    got;
    bit    bad;
    string s_got;
    string s_exp;
    bad = 1'b0; s_got = ""; s_exp = "";
    for (int i = 0; i < 8; i++) begin
      got = int'($signed(u_out.data[i]));
      if (got != exp[i]) bad = 1'b1;
      s_got = {s_got, $sformatf(" %0d", got)};
      s_exp = {s_exp, $sformatf(" %0d", exp[i])};
    end
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL %s: out_data got%s, expected%s at %0t", nm, s_got, s_exp, $time);
    end
  endtask

  // ---------------- cycle-level scoreboard ----------------
  typedef struct {
    bit v;
    int y[8];
  } ent_t;

  ent_t q[$];
  bit   exp_v = 1'b0;
  int   last_y[8] = '{0, 0, 0, 0, 0, 0, 0, 0};

  // Output after edge n reflects the input sampled at edge n-8; reset empties the pipe.
  always @(posedge clk or posedge rst) begin
    ent_t ent;
    int   xs[8];
    if (rst) begin
      q.delete();
      exp_v = 1'b0;
      for (int i = 0; i < 8; i++) last_y[i] = 0;
    end else begin
      ent.v = u_in.valid;
      for (int i = 0; i < 8; i++) xs[i] = int'($signed(u_in.data[i]));
      ref_dct(xs, ent.y);
      q.push_back(ent);
      if (q.size() > 9) void'(q.pop_front());
      if (q.size() == 9 && q[0].v) begin
        exp_v  = 1'b1;
        last_y = q[0].y;
      end else begin
        exp_v = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk_bit("sb_valid", u_out.valid, exp_v);
    chk_vec("sb_data", last_y);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input int x[8]);
    u_in.valid = v;
    for (int i = 0; i < 8; i++) u_in.data[i] = x[i][W_I-1:0];
  endtask

  task automatic rand_vec(output int x[8]);
    logic [W_I-1:0] r;
    for (int i = 0; i < 8; i++) begin
      r    = W_I'($urandom);
      x[i] = int'($signed(r));
    end
  endtask

  // One vector in, wait (bounded) for it, check latency and data.
  task automatic run_vec(input string nm, input int x[8], input int y[8]);
    int n;
    set_in(1'b1, x);
    step();
    u_in.valid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      #1;
      if (u_out.valid) break;
    end
    n_checks++;
    if (n != 8) begin
      n_errors++;
      $display("FAIL %s_latency: got %0d cycles, expected 8", nm, n);
    end
    chk_vec(nm, y);
  endtask

  typedef struct {
    string name;
    int    x[8];
    int    y[8];
  } vec_t;

  vec_t tbl[4];
  int   zeros[8] = '{0, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    int xv[8];
    int yv[8];
    bit pat[6];

    tbl[0].name = "dc";
    tbl[0].x    = '{10, 10, 10, 10, 10, 10, 10, 10};
    tbl[0].y    = '{80, 0, 0, 0, 0, 0, 0, 0};
    tbl[1].name = "impulse";
    tbl[1].x    = '{8, 0, 0, 0, 0, 0, 0, 0};
    tbl[1].y    = '{8, 8, 7, 4, 4, 7, -3, -1};
    tbl[2].name = "neg_impulse";
    tbl[2].x    = '{-8, 0, 0, 0, 0, 0, 0, 0};
    tbl[2].y    = '{-8, -8, -7, -4, -4, -7, 3, 1};
    tbl[3].name = "full_scale";
    tbl[3].x    = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
    tbl[3].y    = '{-262144, 0, 0, 0, 0, 0, 0, 0};

    // Reset held with live input: outputs must stay at zero.
    rand_vec(xv);
    set_in(1'b1, xv);
    for (int c = 0; c < 3; c++) begin
      step();
      chk_bit("reset_valid", u_out.valid, 1'b0);
      chk_vec("reset_data", zeros);
      rand_vec(xv);
      set_in(1'b1, xv);
    end

    // Release; the very next cycle's input is accepted.
    rst = 1'b0;
    for (int t = 0; t < 4; t++) run_vec(tbl[t].name, tbl[t].x, tbl[t].y);

    // Streaming with a bubble: valid pattern reappears 8 cycles later.
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int j = 0; j < 6; j++) begin
      rand_vec(xv);
      set_in(pat[j], xv);
      step();
    end
    u_in.valid = 1'b0;
    repeat (2) @(posedge clk);
    for (int j = 0; j < 6; j++) begin
      @(posedge clk);
      #1;
      chk_bit("stream_pattern", u_out.valid, pat[j]);
    end
    repeat (4) step();

    // Reset mid-burst: in-flight vectors are dropped, nothing stale comes out.
    for (int j = 0; j < 3; j++) begin
      rand_vec(xv);
      set_in(1'b1, xv);
      step();
    end
    rst = 1'b1;
    #1;
    chk_bit("midrst_valid", u_out.valid, 1'b0);
    chk_vec("midrst_data", zeros);
    step();
    rst = 1'b0;
    u_in.valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk_bit("no_stale", u_out.valid, 1'b0);
    end
    rand_vec(xv);
    ref_dct(xv, yv);
    run_vec("after_midrst", xv, yv);

    // Random traffic against the scoreboard.
    for (int c = 0; c < 400; c++) begin
      rand_vec(xv);
      set_in($urandom_range(0, 3) != 0, xv);
      step();
    end
    u_in.valid = 1'b0;
    repeat (12) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
